// File: rtl/controle_escrita_ram.sv
// controle_escrita_ram
// Sole owner of the trail RAM write port. It serialises every write at one
// pixel per clock. After reset it clears the whole screen. From IDLE it
// either clears again on request or stamps a TAM_BLOCO x TAM_BLOCO block of
// one byte at a given top-left pixel.
//
// Ports
//   CLOCK_50        system clock, rising edge
//   reset_n         asynchronous active-low reset
//   limpar          clear request (level, sampled in IDLE, remembered in BLOCO)
//   bloco_req       block stamp request, held high until bloco_ack
//   bloco_x/_y      block top-left pixel coordinate
//   bloco_dado      byte written to every block pixel
//   bloco_ack       1-cycle pulse: block accepted, coincides with first write
//   pronto_limpeza  1-cycle pulse in the cycle after the last clear write
//   ocupado         high whenever the controller is not IDLE
//   wraddress/data/wren  registered RAM write port
module controle_escrita_ram #(
    parameter int LARGURA   = 640,
    parameter int ALTURA    = 480,
    parameter int TAM_BLOCO = 8,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              limpar,
    input  logic              bloco_req,
    input  logic [9:0]        bloco_x,
    input  logic [9:0]        bloco_y,
    input  logic [DATA_W-1:0] bloco_dado,
    output logic              bloco_ack,
    output logic              pronto_limpeza,
    output logic              ocupado,
    output logic [ADDR_W-1:0] wraddress,
    output logic [DATA_W-1:0] data,
    output logic              wren
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LIMPA = 2'd1;
    localparam logic [1:0] BLOCO = 2'd2;

    localparam int              CW     = $clog2(TAM_BLOCO);
    localparam logic [ADDR_W-1:0] TOTAL  = ADDR_W'(LARGURA * ALTURA);
    localparam logic [ADDR_W-1:0] PASSO  = ADDR_W'(LARGURA);
    localparam logic [10:0]     LARG11 = 11'(LARGURA);
    localparam logic [10:0]     ALT11  = 11'(ALTURA);
    localparam logic [CW-1:0]   ULT    = CW'(TAM_BLOCO - 1);

    logic [1:0]        estado;
    logic [ADDR_W-1:0] cnt;       // next clear address
    logic [ADDR_W-1:0] base;      // (by + lin) * LARGURA of the slot on the bus
    logic [9:0]        bx, by;
    logic [CW-1:0]     lin, col;  // row/column of the slot currently on the bus
    logic              pend;      // clear requested while a block was running

    // y * LARGURA as a sum of shifted copies of y. The loop runs over the
    // bits of a constant, so only adders for the set bits of LARGURA remain.
    function automatic logic [ADDR_W-1:0] vezes_largura(input logic [9:0] v);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 11; i++)
            if (LARG11[i]) acc = acc + (ADDR_W'(v) << i);
        return acc;
    endfunction

    // Comparisons are done at 11 bits so x + c never wraps back on screen.
    function automatic logic dentro(input logic [9:0] x, input logic [9:0] y,
                                    input logic [CW-1:0] c, input logic [CW-1:0] r);
        return (({1'b0, x} + 11'(c)) < LARG11) && (({1'b0, y} + 11'(r)) < ALT11);
    endfunction

    logic [CW-1:0]     prox_col, prox_lin;
    logic [ADDR_W-1:0] prox_base, base_req;
    logic              fim_bloco;

    always_comb begin
        fim_bloco = (lin == ULT) && (col == ULT);
        prox_col  = col + CW'(1);
        prox_lin  = lin;
        prox_base = base;
        if (col == ULT) begin
            prox_col  = '0;
            prox_lin  = lin + CW'(1);
            prox_base = base + PASSO;
        end
        base_req = vezes_largura(bloco_y);
    end

    assign ocupado = (estado != IDLE);

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            // Power-up clear starts at address 0 on the first edge after release.
            estado         <= LIMPA;
            cnt            <= '0;
            base           <= '0;
            bx             <= '0;
            by             <= '0;
            lin            <= '0;
            col            <= '0;
            pend           <= 1'b0;
            wren           <= 1'b0;
            wraddress      <= '0;
            data           <= '0;
            bloco_ack      <= 1'b0;
            pronto_limpeza <= 1'b0;
        end else begin
            bloco_ack      <= 1'b0;
            pronto_limpeza <= 1'b0;
            case (estado)
                IDLE: begin
                    wren <= 1'b0;
                    if (limpar) begin
                        estado <= LIMPA;
                        cnt    <= '0;
                    end else if (bloco_req) begin
                        // Slot 0 goes out together with the ack.
                        estado    <= BLOCO;
                        bloco_ack <= 1'b1;
                        bx        <= bloco_x;
                        by        <= bloco_y;
                        base      <= base_req;
                        lin       <= '0;
                        col       <= '0;
                        pend      <= 1'b0;
                        data      <= bloco_dado;
                        wraddress <= base_req + ADDR_W'(bloco_x);
                        wren      <= dentro(bloco_x, bloco_y, '0, '0);
                    end
                end
                LIMPA: begin
                    if (cnt == TOTAL) begin
                        estado         <= IDLE;
                        wren           <= 1'b0;
                        pronto_limpeza <= 1'b1;
                    end else begin
                        wren      <= 1'b1;
                        wraddress <= cnt;
                        data      <= '0;
                        cnt       <= cnt + ADDR_W'(1);
                    end
                end
                BLOCO: begin
                    if (fim_bloco) begin
                        pend <= 1'b0;
                        if (pend || limpar) begin
                            // Deferred clear: address 0 goes out right away.
                            estado    <= LIMPA;
                            wren      <= 1'b1;
                            wraddress <= '0;
                            data      <= '0;
                            cnt       <= ADDR_W'(1);
                        end else begin
                            estado <= IDLE;
                            wren   <= 1'b0;
                        end
                    end else begin
                        // Clipped slots still take their cycle, with wren low.
                        pend      <= pend | limpar;
                        lin       <= prox_lin;
                        col       <= prox_col;
                        base      <= prox_base;
                        wraddress <= prox_base + ADDR_W'(bx) + ADDR_W'(prox_col);
                        wren      <= dentro(bx, by, prox_col, prox_lin);
                    end
                end
                default: begin
                    estado <= IDLE;
                    wren   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/controle_escrita_ram.md
Name: controle_escrita_ram

Overview:
- Owns the write port of the 640x480 trail RAM: on request, stamps an 8x8 player block (one byte per pixel) at a given pixel coordinate, and sweeps the whole memory to zero to clear the screen.
- Sits between the player logic (requester) and the RAM's wraddress/data/wren inputs; the read side (VGA scan) is untouched.
- Serialises all writes at one pixel per CLOCK_50 cycle so that player logic never drives the RAM directly.

Parameters:
LARGURA, 640, screen width in pixels (row pitch of RAM)
ALTURA, 480, screen height in pixels
TAM_BLOCO, 8, block side in pixels
ADDR_W, 19, RAM address width
DATA_W, 8, RAM word width

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous, active-low reset
limpar  in  1  request full-screen clear; level sampled in IDLE
bloco_req  in  1  request block stamp; held until bloco_ack
bloco_x  in  10  block top-left x (pixels)
bloco_y  in  10  block top-left y (pixels)
bloco_dado  in  DATA_W  byte written to every block pixel
bloco_ack  out  1  one-cycle pulse: request accepted, inputs latched
pronto_limpeza  out  1  one-cycle pulse after last clear write
ocupado  out  1  high whenever state != IDLE
wraddress  out  ADDR_W  RAM write address (registered)
data  out  DATA_W  RAM write data (registered)
wren  out  1  RAM write enable (registered)

Behaviour:
- Reset (async assert): wren=0, wraddress=0, data=0, bloco_ack=0, pronto_limpeza=0, state=LIMPA pending start, ocupado=1. Outputs go inactive immediately, with no clock edge needed.
- On reset release: enter LIMPA automatically (power-up clear).
- States: IDLE, LIMPA, BLOCO. Transitions:
  - IDLE -> LIMPA if limpar=1.
  - Else IDLE -> BLOCO if bloco_req=1.
  - limpar has priority when limpar and bloco_req are both high.
- LIMPA:
  - Writes data=0 with wren=1 to addresses 0,1,...,LARGURA*ALTURA-1 (307199), one per cycle, 307200 cycles total.
  - In the cycle after the last write: wren=0, pronto_limpeza=1 for 1 cycle, state=IDLE.
- BLOCO acceptance:
  - The edge that samples bloco_req in IDLE latches x, y and dado.
  - bloco_ack is high in the following cycle, together with the first write (pixel r=0, c=0).
- BLOCO write sequence:
  - 64 pixels are written in row-major order (c fastest), one per cycle.
  - Address = (y+r)*LARGURA + x + c.
  - Address is built from a row-base register incremented by LARGURA per row; no multiplier.
  - Clipping: a pixel with x+c >= LARGURA or y+r >= ALTURA has wren=0 for its slot, but the slot is still consumed. Duration is always exactly 64 cycles.
  - After slot 64: wren=0, state=IDLE.
- ocupado is decoded from the state register. A requester may issue a new bloco_req the cycle ocupado falls.
- limpar asserted during BLOCO: latched into a pending flag; LIMPA starts immediately after the block completes.
- limpar during LIMPA: ignored; no restart.
- bloco_req during LIMPA or BLOCO: not acknowledged; the requester keeps it high and it is served from IDLE.
- Input changes after bloco_ack have no effect on the block in progress.
- Reset mid-operation: the write is aborted instantly and no partial state is kept. After release, the block restarts at LIMPA address 0; any pending flag is cleared.
- Arithmetic:
  - Address adds are done at ADDR_W bits.
  - Coordinate comparisons are done at 11 bits, so x+c cannot wrap.
  - Max legal address is 307199 (fits in 19 bits).

Test Plan:
- Release reset_n -> wren high for 307200 consecutive cycles, wraddress 0..307199 in order, data=0; then pronto_limpeza one pulse; ocupado falls the next cycle.
- IDLE, bloco_req with (216,240), dado=1 -> bloco_ack one pulse. 64 writes of data=1: addresses 153816..153823, then 154456..154463, and so on, last 158303. ocupado low after 64 cycles.
- bloco_req with (636,476), dado=1 -> 64 slots but only 16 wren pulses: x 636..639 on rows 476..479, first address 305276, last 307199.
- bloco_x=1020 -> bloco_ack, zero wren pulses, ocupado high exactly 64 cycles.
- limpar and bloco_req high in the same IDLE cycle -> full clear first, then pronto_limpeza. bloco_ack only after that, with the block written after the clear.
- reset_n low mid-BLOCO (slot 20) -> wren=0 the same cycle. After release, a fresh clear from address 0 with no remaining block writes; limpar pulsed mid-BLOCO without reset -> clear starts the cycle after slot 64.
